detect_ctrl: RTL

- Run-time sequencer for the seizure-detection datapath.
- Pulses the datapath reset and drives its active-low enable.
- Waits for all baselines to become valid, then applies onset/offset hysteresis to the per-sample weighted_sum to raise and clear a registered alarm, followed by a refractory hold-off.
- Sits between the host/config interface and the datapath top.

---
 rtl/detect_pkg.sv | 17 +
 rtl/detect_ctrl_if.sv | 27 ++
 rtl/hyst_counter.sv | 41 ++++
 rtl/detect_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// Shared definitions for the seizure-detection run-time sequencer:
// state encoding, default score width and the 8-bit saturation limit.
package detect_pkg;

  localparam int         WS_W_DEF = 12;
  localparam logic [7:0] SAT_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_WARMUP  = 3'd2,
    ST_MONITOR = 3'd3,
    ST_ALARM   = 3'd4,
    ST_REFRACT = 3'd5
  } state_e;

endpackage

// File: rtl/detect_ctrl_if.sv
// Host/datapath-facing signal bundle of detect_ctrl. The master side drives
// the run requests and datapath status; the slave side is the controller.
interface detect_ctrl_if #(
  parameter int WS_W = detect_pkg::WS_W_DEF
) ();
  logic                   start;
  logic                   stop;
  logic                   sample_vld;
  logic signed [WS_W-1:0] weighted_sum;
  logic                   base_valid;
  logic                   dp_rst;
  logic                   dp_en;
  logic                   alarm;
  logic                   warmup_to;
  logic [2:0]             state;
  logic [7:0]             alarm_count;

  modport master (
    output start, stop, sample_vld, weighted_sum, base_valid,
    input  dp_rst, dp_en, alarm, warmup_to, state, alarm_count
  );

  modport slave (
    input  start, stop, sample_vld, weighted_sum, base_valid,
    output dp_rst, dp_en, alarm, warmup_to, state, alarm_count
  );
endinterface

// File: rtl/hyst_counter.sv
// Saturating 8-bit consecutive-event counter. clr has priority over inc.
// hit flags the inc that brings the run length up to N (or beyond), so the
// caller can act on the same edge the counter reaches N.
module hyst_counter
  import detect_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [7:0] N_M1 = 8'(N - 1);

  logic [7:0] cnt_q, cnt_d;

  // next run length: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc && (cnt_q != SAT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign hit = inc && !clr && (cnt_q >= N_M1);

  // run-length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/detect_ctrl.sv
// Run-time sequencer for the seizure-detection datapath: flushes the
// datapath, waits for baselines, then raises/clears a hysteretic alarm
// followed by a refractory hold-off.
// Optional macro DETECT_CTRL_ALARM_COUNT_EN adds a saturating alarm counter;
// without it alarm_count is tied to zero.
//
// state   | meaning
// IDLE    | datapath held in reset, waiting for start
// FLUSH   | datapath reset held for FLUSH_CYCLES clocks
// WARMUP  | datapath running, waiting for all baselines valid
// MONITOR | counting consecutive hot samples toward onset
// ALARM   | alarm raised, counting consecutive cold samples toward offset
// REFRACT | alarm cleared, ignoring REFRACT_N samples
module detect_ctrl
  import detect_pkg::*;
#(
  parameter int WS_W         = WS_W_DEF,
  parameter int THRESH       = 0,
  parameter int ONSET_N      = 4,
  parameter int OFFSET_N     = 8,
  parameter int REFRACT_N    = 256,
  parameter int FLUSH_CYCLES = 16,
  parameter int WARMUP_MAX   = 4096,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  detect_ctrl_if.slave bus
);

  localparam logic signed [WS_W-1:0] THRESH_WS   = WS_W'(THRESH);
  localparam logic [CNT_W:0]         FLUSH_LIM   = (CNT_W+1)'(FLUSH_CYCLES);
  localparam logic [CNT_W:0]         WARMUP_LIM  = (CNT_W+1)'(WARMUP_MAX);
  localparam logic [CNT_W:0]         REFRACT_LIM = (CNT_W+1)'(REFRACT_N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [CNT_W:0]   cnt_inc;
  logic             dp_rst_q, dp_rst_d;
  logic             dp_en_q, dp_en_d;
  logic             alarm_q, alarm_d;
  logic             warmup_to_q, warmup_to_d;
  logic             start_ok;
  logic             hot;
  logic             onset_inc, onset_clr, onset_hit;
  logic             offset_inc, offset_clr, offset_hit;

  assign hot     = $signed(bus.weighted_sum) >= THRESH_WS;
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];

  // onset run only counts while monitoring, so a hot run from WARMUP is lost
  assign onset_inc  = (state_q == ST_MONITOR) && bus.sample_vld && hot;
  assign onset_clr  = (state_q != ST_MONITOR) || (bus.sample_vld && !hot);
  assign offset_inc = (state_q == ST_ALARM) && bus.sample_vld && !hot;
  assign offset_clr = (state_q != ST_ALARM) || (bus.sample_vld && hot);

  hyst_counter #(.N(ONSET_N)) u_onset (
    .clk   (clk),
    .rst_n (rst),
    .inc   (onset_inc),
    .clr   (onset_clr),
    .hit   (onset_hit)
  );

  hyst_counter #(.N(OFFSET_N)) u_offset (
    .clk   (clk),
    .rst_n (rst),
    .inc   (offset_inc),
    .clr   (offset_clr),
    .hit   (offset_hit)
  );

  // next state, shared counter and registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    warmup_to_d = warmup_to_q;
    start_ok    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d     = ST_FLUSH;
          warmup_to_d = 1'b0;
          start_ok    = 1'b1;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_sat;
        if (cnt_inc >= FLUSH_LIM) state_d = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (bus.sample_vld) cnt_d = cnt_sat;
        if (bus.base_valid) begin
          state_d = ST_MONITOR;
        end else if (bus.sample_vld && (cnt_inc >= WARMUP_LIM)) begin
          state_d     = ST_IDLE;
          warmup_to_d = 1'b1;
        end
      end
      ST_MONITOR: begin
        if (onset_hit) state_d = ST_ALARM;
      end
      ST_ALARM: begin
        if (offset_hit) state_d = ST_REFRACT;
      end
      ST_REFRACT: begin
        if (bus.sample_vld) begin
          cnt_d = cnt_sat;
          if (cnt_inc >= REFRACT_LIM) state_d = ST_MONITOR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // losing a baseline restarts warmup; stop overrides everything
    if (((state_q == ST_MONITOR) || (state_q == ST_ALARM) ||
         (state_q == ST_REFRACT)) && !bus.base_valid) begin
      state_d = ST_WARMUP;
    end
    if ((state_q != ST_IDLE) && bus.stop) state_d = ST_IDLE;

    // every state that uses the shared counter starts it from zero
    if (state_d != state_q) cnt_d = '0;

    dp_rst_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
    dp_en_d  = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
    alarm_d  = (state_d == ST_ALARM);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dp_rst_q    <= 1'b1;
      dp_en_q     <= 1'b1;
      alarm_q     <= 1'b0;
      warmup_to_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_rst_q    <= dp_rst_d;
      dp_en_q     <= dp_en_d;
      alarm_q     <= alarm_d;
      warmup_to_q <= warmup_to_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.dp_rst    = dp_rst_q;
  assign bus.dp_en     = dp_en_q;
  assign bus.alarm     = alarm_q;
  assign bus.warmup_to = warmup_to_q;

`ifdef DETECT_CTRL_ALARM_COUNT_EN
  logic [7:0] alarm_count_q, alarm_count_d;

  // count MONITOR->ALARM transitions, cleared by an accepted start
  always_comb begin
    alarm_count_d = alarm_count_q;
    if (start_ok) begin
      alarm_count_d = 8'd0;
    end else if ((state_q == ST_MONITOR) && (state_d == ST_ALARM) &&
                 (alarm_count_q != SAT_MAX)) begin
      alarm_count_d = alarm_count_q + 8'd1;
    end
  end

  // alarm counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_count_q <= 8'd0;
    end else begin
      alarm_count_q <= alarm_count_d;
    end
  end

  assign bus.alarm_count = alarm_count_q;
`else
  assign bus.alarm_count = 8'd0;
`endif

endmodule
